period_meter: RTL and testbench
===============================

# period_meter

Measures the interval between rising edges of an external pulse train and reports it as a divide value in the same encoding `rate_divider` consumes: a reported value N means one edge every N+1 clocks. It sits in front of the paint datapath's speed control so a tapped or externally clocked input can set brush and cursor rates directly. Raw input is synchronised, edge-detected and glitch-filtered. Idle inputs are flagged with a timeout.

## Interface
- `WIDTH`, 28, counter and output width; matches the `divide` bus.
- `MIN_PERIOD`, 16, minimum accepted edge-to-edge spacing in clocks; closer edges are rejected as glitches.
- `clock` input 1, system clock; all state changes on the rising edge.
- `resetN` input 1, reset, synchronous, active-low.
- `pulseIn` input 1, raw asynchronous pulse source.
- `measured` output WIDTH, last accepted period minus one; holds between measurements.
- `valid` output 1, one-cycle strobe on the cycle `measured` is updated.
- `timeout` output 1, level; high after the input has been silent for 2^WIDTH clocks.
- `busy` output 1, high while in COUNTING.

## Operation
- Input path: 3-flop chain `s1`→`s2`→`s3`. Edge = `s2 & ~s3` (combinational, internal).
- States:
  - IDLE (reset state): counter held at 0.
    - Edge → COUNTING, counter cleared to 0, no `valid`.
  - COUNTING: counter increments by 1 each cycle.
    - Edge with counter ≥ MIN_PERIOD−1: `measured` ← counter, `valid` ← 1 for one cycle, counter cleared to 0, stay in COUNTING.
    - Edge with counter < MIN_PERIOD−1: ignored; counter keeps incrementing, no outputs change.
    - Counter = 2^WIDTH−1 with no edge: → IDLE, `timeout` ← 1, counter ← 0, `measured` retained.
    - Counter = 2^WIDTH−1 with an accepted edge: normal measurement of 2^WIDTH−1; no timeout.
- `timeout` clears only on the next `valid`. The edge that re-enters COUNTING does not clear it.
- Counter never wraps. The saturation check above fires before any increment past the maximum.
- `busy` = (state == COUNTING), registered with the state.

## Timing
- Reset: state IDLE; `s1`/`s2`/`s3`, counter, `measured` and timeout all 0.
  - `valid` = 0, `timeout` = 0, `busy` = 0 the cycle after the reset edge.
- Reset asserted mid-measurement abandons it: no `valid`, `measured` returns to 0.
- `pulseIn` sampled high at clock edge k: edge is detected during the cycle after edge k+1.
  - Resulting `valid` and `measured` update at edge k+2, so they are visible after edge k+2.
- Latency is fixed, so measured period equals true input period in clocks, ±1 from synchroniser sampling.
- `pulseIn` high or low for under 1 clock may be missed; this is required behaviour.
- A level held high produces exactly one edge.
- `valid` is never high on two consecutive cycles, since MIN_PERIOD ≥ 2 is required.

## Configuration
- `PERIOD_METER_AVG_EN`: defined enables two-sample averaging.
  - On each accepted measurement, `measured` ← (previous raw + new raw) >> 1, computed at WIDTH+1 bits, truncating.
  - The first measurement after reset or after leaving IDLE reports the raw value and seeds the previous raw value.
- Undefined: `measured` is the raw counter value. The previous-sample register is not instantiated.

## Test plan
- Reset then `pulseIn` rising every 50 clocks, 5 pulses → 4 `valid` strobes, each `measured` = 49; `busy` = 1 after the first edge.
- Pulses at 50, then an extra edge 5 clocks after one accepted edge (MIN_PERIOD = 16) → glitch ignored; next `measured` = 49.
- WIDTH = 8, one edge then silence → 255 cycles later `timeout` = 1, `busy` = 0, `measured` unchanged.
  - Then pulses every 20 clocks → `timeout` clears with the first `valid`; `measured` = 19.
- `resetN` low for 1 cycle, 30 clocks into a 50-clock period → no `valid`, outputs 0.
  - Next two edges 50 apart give `measured` = 49.
- `PERIOD_METER_AVG_EN` defined, periods 40 then 60 → `measured` = 39, then 49.
- `pulseIn` held high 200 clocks after one prior edge → no further `valid`; timeout only after 2^WIDTH clocks.

Source files
------------

// File: rtl/period_meter_if.sv
// Pulse-input / measurement-output bundle for period_meter.
// Combinational wiring only, no added latency.
// No backpressure: outputs are strobes and levels.
interface period_meter_if #(
    parameter int WIDTH = 28
);
    logic             pulseIn;
    logic [WIDTH-1:0] measured;
    logic             valid;
    logic             timeout;
    logic             busy;

    modport master (output pulseIn, input measured, valid, timeout, busy);
    modport slave  (input pulseIn, output measured, valid, timeout, busy);
endinterface

// File: rtl/period_meter.sv
// Edge-to-edge period meter, reports period-1; PERIOD_METER_AVG_EN adds two-sample averaging.
// Latency: valid/measured update two clocks after pulseIn is first sampled high.
// No backpressure: valid is a one-cycle strobe that must be taken when offered.
module period_meter #(
    parameter int WIDTH      = 28,
    parameter int MIN_PERIOD = 16
) (
    input logic          clock,
    input logic          resetN,
    period_meter_if.slave bus
);
    localparam logic [0:0]       IDLE     = 1'b0;
    localparam logic [0:0]       COUNTING = 1'b1;
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_CNT  = WIDTH'(MIN_PERIOD - 1);

    logic             s1_q, s2_q, s3_q;
    logic             edge_det;
    logic             accept;
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] meas_q, meas_d;
    logic             valid_q, valid_d;
    logic             tout_q, tout_d;

    assign edge_det = s2_q & ~s3_q;
    assign accept   = (state_q == COUNTING) && edge_det && (cnt_q >= MIN_CNT);

`ifdef PERIOD_METER_AVG_EN
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             first_q, first_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] avg;

    assign sum = {1'b0, prev_q} + {1'b0, cnt_q};
    assign avg = WIDTH'(sum >> 1);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        meas_d  = meas_q;
        valid_d = 1'b0;
        tout_d  = tout_q;
`ifdef PERIOD_METER_AVG_EN
        prev_d  = prev_q;
        first_d = first_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (edge_det) begin
                    state_d = COUNTING;
`ifdef PERIOD_METER_AVG_EN
                    first_d = 1'b1;
`endif
                end
            end
            default: begin
                // an accepted edge wins over saturation, so a max-length period still measures
                if (accept) begin
`ifdef PERIOD_METER_AVG_EN
                    meas_d  = first_q ? cnt_q : avg;
                    prev_d  = cnt_q;
                    first_d = 1'b0;
`else
                    meas_d  = cnt_q;
`endif
                    valid_d = 1'b1;
                    tout_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    tout_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            meas_q  <= '0;
            valid_q <= 1'b0;
            tout_q  <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
            prev_q  <= '0;
            first_q <= 1'b0;
`endif
        end else begin
            s1_q    <= bus.pulseIn;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            meas_q  <= meas_d;
            valid_q <= valid_d;
            tout_q  <= tout_d;
`ifdef PERIOD_METER_AVG_EN
            prev_q  <= prev_d;
            first_q <= first_d;
`endif
        end
    end

    assign bus.measured = meas_q;
    assign bus.valid    = valid_q;
    assign bus.timeout  = tout_q;
    assign bus.busy     = (state_q == COUNTING);
endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter at WIDTH=8, MIN_PERIOD=16 against a timestamp-based model.
// Latency: n/a. Backpressure: n/a.
// Stimulus is driven on the falling edge, outputs sampled on the falling edge.
module tb_period_meter;
    localparam int W    = 8;
    localparam int MINP = 16;
    localparam int MAXV = (1 << W) - 1;

    logic clock = 1'b0;
    logic resetN;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    period_meter_if #(.WIDTH(W)) bus ();
    period_meter #(.WIDTH(W), .MIN_PERIOD(MINP)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    // Reference model: pulse history per clock edge, and the edge index of the last accepted edge.
    bit         hist [0:65535];
    int         cyc = 3;
    bit         m_on, m_valid, m_timeout, m_first;
    logic [W-1:0] m_meas;
    int         m_start, m_prev;

    task automatic tick(input bit p, input bit rn);
        bit ev;
        int elapsed, raw;
        bus.pulseIn = p;
        resetN      = rn;
        @(posedge clock);
        cyc++;
        m_valid = 1'b0;
        if (!rn) begin
            hist[cyc] = 0; hist[cyc-1] = 0; hist[cyc-2] = 0;
            m_on = 0; m_timeout = 0; m_meas = '0; m_first = 0; m_prev = 0;
        end else begin
            hist[cyc] = p;
            // a rising edge on the input shows up as an event two edges after it is sampled
            ev = hist[cyc-2] && !hist[cyc-3];
            if (!m_on) begin
                if (ev) begin m_on = 1; m_start = cyc; m_first = 1; end
            end else begin
                elapsed = cyc - 1 - m_start;
                if (ev && elapsed >= MINP - 1) begin
                    raw = elapsed;
`ifdef PERIOD_METER_AVG_EN
                    m_meas = m_first ? W'(raw) : W'((m_prev + raw) / 2);
`else
                    m_meas = W'(raw);
`endif
                    m_prev = raw; m_first = 0;
                    m_valid = 1; m_timeout = 0; m_start = cyc;
                end else if (elapsed == MAXV) begin
                    m_on = 0; m_timeout = 1;
                end
            end
        end
        @(negedge clock);
    endtask

    function automatic bit pulse_at(int t, int start, int period, int n, int hi);
        if (t < start) return 0;
        if ((t - start) / period >= n) return 0;
        return ((t - start) % period) < hi;
    endfunction

    task automatic test_reset;
        tick(0, 0);
        tick(0, 0);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.measured !== 8'd0) begin errors++; $display("FAIL reset_measured: got %0d want 0", bus.measured); end
    endtask

    task automatic test_periodic;
        int nv = 0;
        for (int t = 0; t < 230; t++) begin
            tick(pulse_at(t, 0, 50, 5, 3), 1);
            checks++;
            if ({bus.valid, bus.timeout, bus.busy, bus.measured} !== {m_valid, m_timeout, m_on, m_meas}) begin
                errors++; $display("FAIL periodic_model t=%0d: got v%b t%b b%b m%0d want v%b t%b b%b m%0d", t,
                    bus.valid, bus.timeout, bus.busy, bus.measured, m_valid, m_timeout, m_on, m_meas);
            end
            if (t == 10) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL periodic_busy: got %b want 1", bus.busy); end
            end
            if (bus.valid === 1'b1) begin
                nv++;
                checks++; if (bus.measured !== 8'd49) begin errors++; $display("FAIL periodic_measured: got %0d want 49", bus.measured); end
            end
        end
        checks++; if (nv != 4) begin errors++; $display("FAIL periodic_count: got %0d want 4", nv); end
    endtask

    task automatic test_glitch;
        int nv = 0;
        tick(0, 0);
        for (int t = 0; t < 130; t++) begin
            tick(pulse_at(t, 0, 50, 3, 3) | pulse_at(t, 55, 100, 1, 2), 1);
            checks++;
            if ({bus.valid, bus.timeout, bus.busy, bus.measured} !== {m_valid, m_timeout, m_on, m_meas}) begin
                errors++; $display("FAIL glitch_model t=%0d: got v%b m%0d want v%b m%0d", t,
                    bus.valid, bus.measured, m_valid, m_meas);
            end
            if (bus.valid === 1'b1) begin
                nv++;
                checks++; if (bus.measured !== 8'd49) begin errors++; $display("FAIL glitch_measured: got %0d want 49", bus.measured); end
            end
        end
        checks++; if (nv != 2) begin errors++; $display("FAIL glitch_count: got %0d want 2", nv); end
    endtask

    task automatic test_timeout;
        bit seen = 0;
        tick(0, 0);
        for (int t = 0; t < 480; t++) begin
            tick(pulse_at(t, 0, 50, 2, 3) | pulse_at(t, 400, 20, 4, 3), 1);
            checks++;
            if ({bus.valid, bus.timeout, bus.busy, bus.measured} !== {m_valid, m_timeout, m_on, m_meas}) begin
                errors++; $display("FAIL timeout_model t=%0d: got v%b t%b b%b m%0d want v%b t%b b%b m%0d", t,
                    bus.valid, bus.timeout, bus.busy, bus.measured, m_valid, m_timeout, m_on, m_meas);
            end
            if (t == 399) begin
                checks++; if ({bus.timeout, bus.busy} !== 2'b10) begin errors++; $display("FAIL timeout_flag: got t%b b%b want t1 b0", bus.timeout, bus.busy); end
                checks++; if (bus.measured !== 8'd49) begin errors++; $display("FAIL timeout_hold: got %0d want 49", bus.measured); end
            end
            if (t == 410) begin
                checks++; if ({bus.timeout, bus.busy} !== 2'b11) begin errors++; $display("FAIL timeout_reentry: got t%b b%b want t1 b1", bus.timeout, bus.busy); end
            end
            if (t > 400 && bus.valid === 1'b1 && !seen) begin
                seen = 1;
                checks++; if ({bus.timeout, bus.measured} !== {1'b0, 8'd19}) begin errors++; $display("FAIL timeout_clear: got t%b m%0d want t0 m19", bus.timeout, bus.measured); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL timeout_resume: got no valid want valid"); end
    endtask

    task automatic test_reset_mid;
        int nv = 0;
        tick(0, 0);
        for (int t = 0; t < 140; t++) begin
            tick(pulse_at(t, 0, 50, 1, 3) | pulse_at(t, 50, 50, 2, 3), t != 30);
            checks++;
            if ({bus.valid, bus.timeout, bus.busy, bus.measured} !== {m_valid, m_timeout, m_on, m_meas}) begin
                errors++; $display("FAIL resetmid_model t=%0d: got v%b m%0d want v%b m%0d", t,
                    bus.valid, bus.measured, m_valid, m_meas);
            end
            if (t == 30) begin
                checks++; if ({bus.valid, bus.timeout, bus.busy, bus.measured} !== 11'd0) begin
                    errors++; $display("FAIL resetmid_outputs: got v%b t%b b%b m%0d want all 0", bus.valid, bus.timeout, bus.busy, bus.measured);
                end
            end
            if (bus.valid === 1'b1) begin
                nv++;
                checks++; if (bus.measured !== 8'd49) begin errors++; $display("FAIL resetmid_measured: got %0d want 49", bus.measured); end
            end
        end
        checks++; if (nv != 1) begin errors++; $display("FAIL resetmid_count: got %0d want 1", nv); end
    endtask

    task automatic test_avg;
        int nv = 0;
        tick(0, 0);
        for (int t = 0; t < 130; t++) begin
            tick(pulse_at(t, 0, 40, 2, 3) | pulse_at(t, 100, 1000, 1, 3), 1);
            checks++;
            if ({bus.valid, bus.measured} !== {m_valid, m_meas}) begin
                errors++; $display("FAIL avg_model t=%0d: got v%b m%0d want v%b m%0d", t, bus.valid, bus.measured, m_valid, m_meas);
            end
            if (bus.valid === 1'b1) begin
                nv++;
                if (nv == 1) begin
                    checks++; if (bus.measured !== 8'd39) begin errors++; $display("FAIL avg_first: got %0d want 39", bus.measured); end
                end else begin
`ifdef PERIOD_METER_AVG_EN
                    checks++; if (bus.measured !== 8'd49) begin errors++; $display("FAIL avg_second: got %0d want 49", bus.measured); end
`else
                    checks++; if (bus.measured !== 8'd59) begin errors++; $display("FAIL avg_second: got %0d want 59", bus.measured); end
`endif
                end
            end
        end
        checks++; if (nv != 2) begin errors++; $display("FAIL avg_count: got %0d want 2", nv); end
    endtask

    task automatic test_held_high;
        int nv = 0;
        tick(0, 0);
        for (int t = 0; t < 400; t++) begin
            tick(pulse_at(t, 0, 50, 1, 3) | (t >= 50 && t < 250), 1);
            checks++;
            if ({bus.valid, bus.timeout, bus.busy, bus.measured} !== {m_valid, m_timeout, m_on, m_meas}) begin
                errors++; $display("FAIL held_model t=%0d: got v%b t%b b%b want v%b t%b b%b", t,
                    bus.valid, bus.timeout, bus.busy, m_valid, m_timeout, m_on);
            end
            if (bus.valid === 1'b1) nv++;
            if (t == 249) begin
                checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL held_early_timeout: got %b want 0", bus.timeout); end
            end
        end
        checks++; if (nv != 1) begin errors++; $display("FAIL held_count: got %0d want 1", nv); end
        checks++; if ({bus.timeout, bus.busy} !== 2'b10) begin errors++; $display("FAIL held_timeout: got t%b b%b want t1 b0", bus.timeout, bus.busy); end
    endtask

    task automatic test_random;
        int gap = 0, hi = 0, remain = 0;
        bit p, rn;
        tick(0, 0);
        for (int t = 0; t < 3000; t++) begin
            if (remain == 0) begin
                gap    = ($urandom_range(0, 15) == 0) ? int'($urandom_range(200, 320)) : int'($urandom_range(3, 60));
                hi     = int'($urandom_range(1, (gap > 6) ? 5 : gap - 1));
                remain = gap;
            end
            p  = (gap - remain) < hi;
            remain--;
            rn = ($urandom_range(0, 499) != 0);
            tick(p, rn);
            checks++;
            if ({bus.valid, bus.timeout, bus.busy, bus.measured} !== {m_valid, m_timeout, m_on, m_meas}) begin
                errors++; $display("FAIL random_model t=%0d: got v%b t%b b%b m%0d want v%b t%b b%b m%0d", t,
                    bus.valid, bus.timeout, bus.busy, bus.measured, m_valid, m_timeout, m_on, m_meas);
            end
        end
    endtask

    initial begin
        bus.pulseIn = 1'b0;
        resetN      = 1'b0;
        test_reset();
        test_periodic();
        test_glitch();
        test_timeout();
        test_reset_mid();
        test_avg();
        test_held_high();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
